gelato_l2_cache_responder: RTL and testbench
============================================

Name: gelato_l2_cache_responder

Overview:
- L2-side responder of the L1↔L2 request/response link: consumes L1 read requests (valid/addr) and returns one data word with a single-cycle done pulse.
- Direct-mapped, read-only, one word per line; misses are filled from a backing-memory request/response port.
- Sits between the L1 caches and the memory controller; exports hit/miss counters for performance monitoring.

Parameters:
- ADDR_WIDTH, 32, byte-address width (matches addr_t)
- DATA_WIDTH, 32, word width (matches data_t); must be a power of two ≥ 8
- NUM_LINES, 64, number of cache lines; power of two ≥ 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  L1 request valid; held high with addr stable until done
- addr  in  ADDR_WIDTH  L1 request byte address
- done  out  1  one-cycle response pulse
- data  out  DATA_WIDTH  response word, valid only while done=1
- flush  in  1  single-cycle pulse, invalidates all lines
- mem_req_valid  out  1  fill request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  word-aligned fill address
- mem_resp_valid  in  1  fill data valid
- mem_resp_data  in  DATA_WIDTH  fill data
- hit_cnt  out  32  hits since reset, wraps
- miss_cnt  out  32  misses since reset, wraps

Behaviour:
- Address split: OFF = log2(DATA_WIDTH/8) low bits ignored; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: per line, one valid bit, one tag and one data word, all in registers. Valid bits are cleared by reset; tag and data are not reset.
- Reset (async, rst_n=0): state=IDLE; done=0, data=0, mem_req_valid=0, mem_req_addr=0, hit_cnt=0, miss_cnt=0; all valid bits cleared. Reset mid-miss abandons the fill; mem_resp_valid seen outside MISS_WAIT is ignored.
- FSM states and transitions:
  - IDLE: if valid=1, latch addr into req_addr and go to LOOKUP.
  - LOOKUP: hit = line valid && tag match. On hit, load data register with line data, hit_cnt+1, go to RESP. On miss, miss_cnt+1, mem_req_addr = req_addr with offset bits zeroed, go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1 and mem_req_addr held stable. When mem_req_ready=1 in the same cycle, go to MISS_WAIT; mem_req_valid drops the next cycle.
  - MISS_WAIT: on mem_resp_valid=1, write data and tag, set the line valid, load the data register, go to RESP.
  - RESP: done=1 for exactly one cycle with data; go to IDLE.
- Latency, counted from the cycle valid is first sampled in IDLE:
  - hit: done at +2;
  - miss with ready and response each returned the cycle they are first possible: done at +4.
- done is never asserted outside RESP. valid is not sampled in RESP.
- L1 deasserts valid in the cycle after done. If valid is still high in IDLE, it is a new request.
- valid dropping before done is a protocol violation and the request completes anyway.
- flush=1: all valid bits are cleared at the end of that cycle.
  - A LOOKUP in the same cycle uses the pre-flush valid bits.
  - A fill completing in the same cycle as flush still returns data to L1 but leaves the line invalid (flush wins).
  - flush never aborts an in-flight request.
- Counters wrap from 2^32-1 to 0.

Test Plan:
- Cold miss: after reset, valid=1, addr=0x0000_0040; memory ready at once, returns 0xDEAD_BEEF one cycle after the request → mem_req_addr=0x40, done pulses once with data=0xDEAD_BEEF at +4, miss_cnt=1.
- Hit: repeat addr 0x40 → no mem_req_valid, done at +2 with 0xDEAD_BEEF, hit_cnt=1. Also addr 0x43 (same word) → hit.
- Conflict: NUM_LINES=64, so 0x40 and 0x140 share index 16. Access 0x140 (fill 0x1111_1111), then 0x40 → both miss, miss_cnt=3; 0x40 returns its fresh fill data.
- Backpressure: mem_req_ready held low for 5 cycles → mem_req_valid and mem_req_addr stay stable, done=0 throughout; done follows response + 1.
- Flush: fill 0x40, pulse flush, read 0x40 → miss. Flush coincident with the mem_resp_valid cycle → done with fill data, but the next read of the same address misses.
- Reset in MISS_WAIT: rst_n low mid-miss, then a stray mem_resp_valid arrives → no done, counters=0, and the next request behaves as a cold miss.

Source files
------------

// File: rtl/gelato_l2_cache_responder.sv
// L2 responder for the L1<->L2 read link: direct-mapped, read-only, one word per line,
// misses filled through a memory request/response port, with hit/miss counters.
module gelato_l2_cache_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX = $clog2(NUM_LINES);
    localparam int unsigned TAG = ADDR_WIDTH - OFF - IDX;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StMissWait,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic [NUM_LINES-1:0]  line_valid_q, line_valid_d;
    logic [TAG-1:0]        tag_q [NUM_LINES];
    logic [DATA_WIDTH-1:0] line_data_q [NUM_LINES];

    logic [IDX-1:0] req_idx;
    logic [TAG-1:0] req_tag;
    logic           hit;
    logic           fill;

    assign req_idx = req_addr_q[OFF +: IDX];
    assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG];
    assign hit     = line_valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill    = (state_q == StMissWait) && mem_resp_valid;

    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        mem_req_addr_d = mem_req_addr_q;
        data_d         = data_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        line_valid_d   = line_valid_q;

        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    req_addr_d = addr;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    data_d    = line_data_q[req_idx];
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = StResp;
                end else begin
                    miss_cnt_d     = miss_cnt_q + 32'd1;
                    mem_req_addr_d = req_addr_q & ~OFF_MASK;
                    state_d        = StMissReq;
                end
            end
            StMissReq: begin
                if (mem_req_ready) state_d = StMissWait;
            end
            StMissWait: begin
                if (mem_resp_valid) begin
                    data_d                = mem_resp_data;
                    line_valid_d[req_idx] = 1'b1;
                    state_d               = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush applies after the lookup/fill of this cycle, so it wins over a same-cycle fill.
        if (flush) line_valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            req_addr_q     <= '0;
            mem_req_addr_q <= '0;
            data_q         <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            line_valid_q   <= '0;
        end else begin
            state_q        <= state_d;
            req_addr_q     <= req_addr_d;
            mem_req_addr_q <= mem_req_addr_d;
            data_q         <= data_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            line_valid_q   <= line_valid_d;
        end
    end

    // Tag and data arrays are qualified by line_valid_q and need no reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[req_idx]       <= req_tag;
            line_data_q[req_idx] <= mem_resp_data;
        end
    end

    assign done          = (state_q == StResp);
    assign data          = data_q;
    assign mem_req_valid = (state_q == StMissReq);
    assign mem_req_addr  = mem_req_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_gelato_l2_cache_responder.sv
// Bench for gelato_l2_cache_responder: directed scenarios plus a randomized run, each
// checked against an address-arithmetic cache model with a scripted memory responder.
module tb_gelato_l2_cache_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic        done;
    logic [31:0] data;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: 64 lines of 4-byte words.
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    gelato_l2_cache_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .addr           (addr),
        .done           (done),
        .data           (data),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_access(input logic [31:0] a, input logic [31:0] fd, input bit fl,
                                output bit h, output logic [31:0] ed);
        int unsigned idx;
        logic [23:0] tg;
        idx = (a / 4) % 64;
        tg  = 24'(a / 256);
        h = m_valid[idx] && (m_tag[idx] == tg);
        if (h) begin
            ed = m_data[idx];
            m_hits++;
        end else begin
            ed = fd;
            m_misses++;
            m_tag[idx]  = tg;
            m_data[idx] = fd;
            if (fl) model_flush();
            else m_valid[idx] = 1'b1;
        end
    endtask

    // Issues one L1 read and plays memory: ready after rd cycles of request, response
    // rsd cycles into the wait, optionally with flush on the response cycle.
    task automatic do_read(input logic [31:0] a, input int rd, input int rsd,
                           input logic [31:0] fd, input bit fl,
                           output int lat, output logic [31:0] got, output bit saw_req,
                           output logic [31:0] raddr, output bit unstable,
                           output bit extra_done);
        int req_cycles = 0;
        int wait_cycles = 0;
        bit accepted = 1'b0;
        lat = -1; got = '0; saw_req = 1'b0; raddr = '0; unstable = 1'b0; extra_done = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
            if (done) begin
                lat = k;
                got = data;
                break;
            end
            if (mem_req_valid) begin
                if (saw_req && mem_req_addr !== raddr) unstable = 1'b1;
                if (!saw_req) raddr = mem_req_addr;
                saw_req = 1'b1;
                if (req_cycles >= rd) begin
                    mem_req_ready = 1'b1;
                    accepted = 1'b1;
                end
                req_cycles++;
            end else if (accepted) begin
                if (wait_cycles == rsd) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = fd;
                    flush          = fl;
                end
                wait_cycles++;
            end
        end
        valid = 1'b0;
        @(negedge clk);
        if (done) extra_done = 1'b1;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
    endtask

    // One read checked against the model: latency, data, fill request and counters.
    task automatic test_access(input string name, input logic [31:0] a, input int rd,
                               input int rsd, input logic [31:0] fd, input bit fl);
        int lat;
        logic [31:0] got, raddr, ed;
        bit saw_req, unstable, extra, h;
        int exp_lat;
        model_access(a, fd, fl, h, ed);
        do_read(a, rd, rsd, fd, fl, lat, got, saw_req, raddr, unstable, extra);
        exp_lat = h ? 2 : 4 + rd + rsd;
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d (addr %h)", name, lat, exp_lat, a);
        end
        checks++;
        if (got !== ed) begin
            failures++;
            $display("FAIL %s data: got %h expected %h (addr %h)", name, got, ed, a);
        end
        checks++;
        if (saw_req !== !h) begin
            failures++;
            $display("FAIL %s mem_req seen: got %0d expected %0d (addr %h)", name, saw_req, !h, a);
        end
        if (!h) begin
            checks++;
            if (raddr !== (a & ~32'h3) || unstable) begin
                failures++;
                $display("FAIL %s mem_req_addr: got %h unstable %0d expected %h",
                         name, raddr, unstable, a & ~32'h3);
            end
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL %s done width: got 2+ cycles expected 1", name);
        end
        checks++;
        if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            failures++;
            $display("FAIL %s counters: got hit %0d miss %0d expected hit %0d miss %0d",
                     name, hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || data !== 32'h0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0
            || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset outputs: got done %b data %h mrv %b mra %h hit %0d miss %0d expected all 0",
                     done, data, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        test_access("cold_miss", 32'h40, 0, 0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_hit();
        test_access("hit_40", 32'h40, 0, 0, 32'h0, 1'b0);
        test_access("hit_43", 32'h43, 0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_conflict();
        test_access("conflict_140", 32'h140, 0, 0, 32'h1111_1111, 1'b0);
        test_access("conflict_40", 32'h40, 0, 0, $urandom, 1'b0);
        checks++;
        if (miss_cnt !== 32'd3) begin
            failures++;
            $display("FAIL conflict miss_cnt: got %0d expected 3", miss_cnt);
        end
    endtask

    task automatic test_backpressure();
        test_access("backpressure", 32'h0000_2A04, 5, 2, $urandom, 1'b0);
    endtask

    task automatic test_flush();
        test_access("flush_pre", 32'h40, 0, 0, 32'h0, 1'b0);
        flush_pulse();
        test_access("flush_post", 32'h40, 0, 0, $urandom, 1'b0);
        test_access("flush_at_fill", 32'h80, 0, 1, $urandom, 1'b1);
        test_access("flush_after_fill", 32'h80, 0, 0, $urandom, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) flush_pulse();
            test_access("random", a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                        $urandom_range(0, 5) == 0);
        end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h0000_0600;
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL stray_resp done: got %b expected 0 (cycle %0d)", done, k);
            end
        end
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_miss counters: got hit %0d miss %0d expected 0 0",
                     hit_cnt, miss_cnt);
        end
        test_access("post_reset_cold", 32'h40, 0, 0, 32'hC0FF_EE00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
